// File: rtl/multi_memory.sv
// Shared single-bank memory with REQUESTERS read and write ports, each side
// arbitrated by its own round-robin pointer; reads return data one cycle later.

module multi_memory_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] memory [0:(2**ADDR_WIDTH)-1];

    // Asynchronous read: the top samples this at the same edge as the write,
    // which yields the old word on a same-address collision.
    assign rdata = memory[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            memory[waddr] <= wdata;
        end
    end

endmodule

module multi_memory #(
    parameter int REQUESTERS = 3,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] r_addr,
    input  logic [REQUESTERS-1:0]            r_avalid,
    output logic [REQUESTERS-1:0]            r_aready,
    output logic [REQUESTERS-1:0]            r_dvalid,
    output logic [REQUESTERS*DATA_WIDTH-1:0] r_data,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] w_addr,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] w_data,
    input  logic [REQUESTERS-1:0]            w_valid,
    output logic [REQUESTERS-1:0]            w_ready
);

    localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] r_addr_v;
    logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] w_addr_v;
    logic [REQUESTERS-1:0][DATA_WIDTH-1:0] w_data_v;

    logic [IDX_W-1:0]                      rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]                      wr_ptr_q, wr_ptr_d;
    logic [REQUESTERS-1:0]                 r_dvalid_q, r_dvalid_d;
    logic [REQUESTERS-1:0][DATA_WIDTH-1:0] r_data_q, r_data_d;

    logic                  rd_found, wr_found;
    logic [IDX_W-1:0]      rd_idx, wr_idx;
    logic [REQUESTERS-1:0] rd_gnt, wr_gnt;
    logic [DATA_WIDTH-1:0] bank_rdata;

    assign r_addr_v = r_addr;
    assign w_addr_v = w_addr;
    assign w_data_v = w_data;

    // Returns {found, index} of the first requester at or after 'start', wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [REQUESTERS-1:0] req,
                                               input logic [IDX_W-1:0]      start);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               p;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            p = int'(start) + k;
            if (p >= REQUESTERS) p = p - REQUESTERS;
            if (!found && req[p]) begin
                found = 1'b1;
                idx   = p[IDX_W-1:0];
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(REQUESTERS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    always_comb begin
        {rd_found, rd_idx} = rr_pick(r_avalid, rd_ptr_q);
        {wr_found, wr_idx} = rr_pick(w_valid, wr_ptr_q);
        rd_gnt = '0;
        wr_gnt = '0;
        rd_gnt[rd_idx] = rd_found;
        wr_gnt[wr_idx] = wr_found;
    end

    assign r_aready = rd_gnt;
    assign w_ready  = wr_gnt;

    multi_memory_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) memory (
        .clk  (clk),
        .we   (wr_found),
        .waddr(w_addr_v[wr_idx]),
        .wdata(w_data_v[wr_idx]),
        .raddr(r_addr_v[rd_idx]),
        .rdata(bank_rdata)
    );

    // Pointers advance only on a granted cycle; read data is held per port until its next grant.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        r_dvalid_d = rd_gnt;
        r_data_d   = r_data_q;
        if (rd_found) begin
            rd_ptr_d         = rr_next(rd_idx);
            r_data_d[rd_idx] = bank_rdata;
        end
        if (wr_found) begin
            wr_ptr_d = rr_next(wr_idx);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            r_dvalid_q <= '0;
            r_data_q   <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            r_dvalid_q <= r_dvalid_d;
            r_data_q   <= r_data_d;
        end
    end

    assign r_dvalid = r_dvalid_q;
    assign r_data   = r_data_q;

endmodule

// File: tb/tb_multi_memory.sv
// Self-checking bench for multi_memory: directed scenarios plus random traffic
// compared against an array-based memory model with round-robin grant rules.

module tb_multi_memory;

    logic        clk;
    logic        rst;
    logic [47:0] r_addr;
    logic [2:0]  r_avalid;
    logic [2:0]  r_aready;
    logic [2:0]  r_dvalid;
    logic [47:0] r_data;
    logic [47:0] w_addr;
    logic [47:0] w_data;
    logic [2:0]  w_valid;
    logic [2:0]  w_ready;

    int checks = 0;
    int errors = 0;

    logic [15:0] modelMem [0:65535];
    logic [15:0] expData [3];
    int          rdNext;
    int          wrNext;
    int          grantCount [3];

    multi_memory #(
        .REQUESTERS(3),
        .DATA_WIDTH(16),
        .ADDR_WIDTH(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .r_addr  (r_addr),
        .r_avalid(r_avalid),
        .r_aready(r_aready),
        .r_dvalid(r_dvalid),
        .r_data  (r_data),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .w_valid (w_valid),
        .w_ready (w_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Round-robin winner: first requester scanning start, start+1, ... modulo 3.
    function automatic int pickWinner(input logic [2:0] req, input int start);
        for (int k = 0; k < 3; k++) begin
            if (req[(start + k) % 3]) return (start + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [15:0] randAddr();
        return ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
    endfunction

    // Called just after a falling edge; returns after the next falling edge.
    task automatic applyStimulus(input logic [2:0] rav, input logic [47:0] ra,
                                 input logic [2:0] wv, input logic [47:0] wa,
                                 input logic [47:0] wd, output int rg);
        int         wg;
        logic [2:0] expRdy;
        logic [2:0] expWrdy;
        r_avalid = rav;
        r_addr   = ra;
        w_valid  = wv;
        w_addr   = wa;
        w_data   = wd;
        #1;
        rg      = pickWinner(rav, rdNext);
        wg      = pickWinner(wv, wrNext);
        expRdy  = (rg >= 0) ? 3'(1 << rg) : 3'b000;
        expWrdy = (wg >= 0) ? 3'(1 << wg) : 3'b000;
        checkOutput("r_aready", 64'(r_aready), 64'(expRdy));
        checkOutput("w_ready", 64'(w_ready), 64'(expWrdy));
        if (rg >= 0) begin
            expData[rg] = modelMem[ra[rg*16 +: 16]];
            rdNext      = (rg + 1) % 3;
            grantCount[rg]++;
        end
        if (wg >= 0) begin
            modelMem[wa[wg*16 +: 16]] = wd[wg*16 +: 16];
            wrNext = (wg + 1) % 3;
        end
        @(posedge clk);
        #1;
        checkOutput("r_dvalid", 64'(r_dvalid), 64'(expRdy));
        checkOutput("r_data", 64'(r_data), 64'({expData[2], expData[1], expData[0]}));
        @(negedge clk);
    endtask

    task automatic resetModel();
        rdNext = 0;
        wrNext = 0;
        for (int i = 0; i < 3; i++) expData[i] = 16'h0000;
    endtask

    task automatic doReset();
        rst      = 1'b0;
        r_avalid = '0;
        w_valid  = '0;
        r_addr   = '0;
        w_addr   = '0;
        w_data   = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_dvalid", 64'(r_dvalid), 64'h0);
        checkOutput("reset_data", 64'(r_data), 64'h0);
        checkOutput("reset_aready", 64'(r_aready), 64'h0);
        resetModel();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int          rg;
        logic [2:0]  pend;
        logic [47:0] ra;
        logic [47:0] wa;
        logic [47:0] wd;

        rst = 1'b0;
        for (int a = 0; a < 65536; a++) begin
            dut.memory.memory[a] = 16'(a);
            modelMem[a]          = 16'(a);
        end
        doReset();

        $display("[TB] single read");
        applyStimulus(3'b001, {32'h0, 16'h0010}, 3'b000, '0, '0, rg);
        checkOutput("read0_data", 64'(r_data[15:0]), 64'h0010);
        applyStimulus(3'b000, '0, 3'b000, '0, '0, rg);

        $display("[TB] three simultaneous reads");
        doReset();
        pend = 3'b111;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(pend, {16'h0210, 16'h0110, 16'h0010}, 3'b000, '0, '0, rg);
            checkOutput($sformatf("order%0d", k), 64'(rg), 64'(k));
            if (rg >= 0) pend[rg] = 1'b0;
        end
        checkOutput("p0_data", 64'(r_data[15:0]), 64'h0010);
        checkOutput("p1_data", 64'(r_data[31:16]), 64'h0110);
        checkOutput("p2_data", 64'(r_data[47:32]), 64'h0210);

        $display("[TB] back-to-back reads on port 2");
        for (int a = 16'h0212; a <= 16'h0218; a++) begin
            applyStimulus(3'b100, {16'(a), 32'h0}, 3'b000, '0, '0, rg);
            checkOutput($sformatf("b2b_%0h", a), 64'(r_data[47:32]), 64'(16'(a)));
        end

        $display("[TB] write then read");
        applyStimulus(3'b000, '0, 3'b001, {32'h0, 16'h0212}, {32'h0, 16'hA012}, rg);
        applyStimulus(3'b010, {16'h0, 16'h0212, 16'h0}, 3'b000, '0, '0, rg);
        checkOutput("wr_rd", 64'(r_data[31:16]), 64'hA012);

        $display("[TB] same-edge collision");
        applyStimulus(3'b010, {16'h0, 16'h0005, 16'h0}, 3'b001, {32'h0, 16'h0005}, {32'h0, 16'h1234}, rg);
        checkOutput("collide_old", 64'(r_data[31:16]), 64'h0005);
        applyStimulus(3'b010, {16'h0, 16'h0005, 16'h0}, 3'b000, '0, '0, rg);
        checkOutput("collide_new", 64'(r_data[31:16]), 64'h1234);

        $display("[TB] reset with read in flight");
        applyStimulus(3'b010, {16'h0, 16'h0010, 16'h0}, 3'b000, '0, '0, rg);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_dvalid", 64'(r_dvalid), 64'h0);
        checkOutput("midrst_data", 64'(r_data), 64'h0);
        resetModel();
        r_avalid = '0;
        w_valid  = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(3'b000, '0, 3'b000, '0, '0, rg);
        applyStimulus(3'b111, {16'h0003, 16'h0002, 16'h0001}, 3'b000, '0, '0, rg);
        checkOutput("ptr_after_rst", 64'(rg), 64'h0);

        $display("[TB] fairness over 30 cycles");
        for (int i = 0; i < 3; i++) grantCount[i] = 0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(3'b111, {randAddr(), randAddr(), randAddr()}, 3'b000, '0, '0, rg);
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("fair%0d", i), 64'(grantCount[i]), 64'd10);
        end

        $display("[TB] random traffic");
        for (int c = 0; c < 300; c++) begin
            ra = {randAddr(), randAddr(), randAddr()};
            wa = {randAddr(), randAddr(), randAddr()};
            wd = {16'($urandom), 16'($urandom), 16'($urandom)};
            applyStimulus(3'($urandom), ra, 3'($urandom), wa, wd, rg);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
